// File: rtl/link_arb_pkg.sv
// link_arb_pkg: shared types and constants for the link transmit arbiter.
// Holds the frame-sequencer state encoding, datapath widths and the default
// preamble pattern used by link_tx_arbiter and rr_arbiter.
package link_arb_pkg;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  localparam logic [DATA_W-1:0] PREAMBLE_WORD_DEFAULT = 32'hA5A5_5A5A;

  typedef enum logic [1:0] {
    ST_ARB      = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_GUARD    = 2'd3
  } state_t;

endpackage

// File: rtl/link_tx_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin winner search with a registered last-winner pointer.
// The search starts one position past rr_ptr and wraps; the pointer moves to
// the winner only when grant_en is asserted by the frame sequencer.
module rr_arbiter
  import link_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               grant_en,
  output logic               any_req,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx
);

  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_ptr_d;

  // Combinational search: walk offsets from farthest to nearest so the
  // nearest requester after rr_ptr is the last (winning) assignment.
  always_comb begin
    int idx;
    any_req    = |req;
    winner_idx = rr_ptr_q;
    idx        = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (req[idx]) begin
        winner_idx = IDX_W'(idx);
      end
    end
    winner   = any_req ? (NUM_REQ'(1) << winner_idx) : '0;
    rr_ptr_d = grant_en ? winner_idx : rr_ptr_q;
  end

  // Pointer register; reset leaves requester 0 with first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/link_tx_arbiter.sv
// link_tx_arbiter: shares one outbound link between NUM_REQ requesters.
// Per frame: ARB (pick winner, latch length) -> PREAMBLE (fixed pattern) ->
// PAYLOAD (granted requester's words, flagged for scrambling) -> GUARD gap.
// Optional build macro LINK_ARB_TIMEOUT_EN adds a payload stall timeout that
// pulses abort and ends the frame without out_last.
module link_tx_arbiter
  import link_arb_pkg::*;
#(
  parameter int                NUM_REQ        = 4,
  parameter int                PREAMBLE_LEN   = 4,
  parameter logic [DATA_W-1:0] PREAMBLE_WORD  = PREAMBLE_WORD_DEFAULT,
  parameter int                GUARD_CYCLES   = 2,
  parameter int                TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       scramble_en,
  output logic                       abort
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);
  localparam int GRD_W = $clog2(GUARD_CYCLES + 1);

  // Reject unsupported parameter combinations at elaboration time.
  if (NUM_REQ < 2 || NUM_REQ > 8 || PREAMBLE_LEN < 1 || GUARD_CYCLES < 1 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("link_tx_arbiter: unsupported parameter set");
  end

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [LEN_W-1:0]   len_cnt_q, len_cnt_d;
  logic [GRD_W-1:0]   guard_cnt_q, guard_cnt_d;

  logic               any_req;
  logic [NUM_REQ-1:0] winner;
  logic [IDX_W-1:0]   winner_idx;
  logic               arb_take;
  logic               gnt_valid;
  logic [DATA_W-1:0]  gnt_data;
  logic               last_pre;

`ifdef LINK_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               abort_q, abort_d;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant_en   (arb_take),
    .any_req    (any_req),
    .winner     (winner),
    .winner_idx (winner_idx)
  );

  assign gnt_valid = req_valid[gidx_q];
  assign gnt_data  = req_data[gidx_q*DATA_W +: DATA_W];
  assign last_pre  = (pre_cnt_q == PRE_W'(PREAMBLE_LEN - 1));
  assign grant     = grant_q;
  assign busy      = (state_q != ST_ARB);

  // Frame sequencer: next state, counters and link outputs per state.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    pre_cnt_d   = pre_cnt_q;
    len_cnt_d   = len_cnt_q;
    guard_cnt_d = guard_cnt_q;
    arb_take    = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_last    = 1'b0;
    scramble_en = 1'b0;
    req_ready   = '0;
`ifdef LINK_ARB_TIMEOUT_EN
    stall_cnt_d = stall_cnt_q;
    abort_d     = 1'b0;
`endif
    unique case (state_q)
      ST_ARB: begin
        if (any_req) begin
          arb_take  = 1'b1;
          grant_d   = winner;
          gidx_d    = winner_idx;
          len_cnt_d = req_len[winner_idx*LEN_W +: LEN_W];
          pre_cnt_d = '0;
          state_d   = ST_PREAMBLE;
`ifdef LINK_ARB_TIMEOUT_EN
          stall_cnt_d = '0;
`endif
        end
      end
      ST_PREAMBLE: begin
        out_valid = 1'b1;
        out_data  = PREAMBLE_WORD;
        // A zero-length frame ends on its final preamble word.
        out_last  = last_pre && (len_cnt_q == '0);
        if (out_ready) begin
          pre_cnt_d = pre_cnt_q + 1'b1;
          if (last_pre) begin
            guard_cnt_d = '0;
            if (len_cnt_q == '0) begin
              state_d = ST_GUARD;
              grant_d = '0;
            end else begin
              state_d = ST_PAYLOAD;
            end
          end
        end
      end
      ST_PAYLOAD: begin
        out_valid = gnt_valid;
        if (gnt_valid) begin
          out_data    = gnt_data;
          scramble_en = 1'b1;
          out_last    = (len_cnt_q == LEN_W'(1));
          req_ready   = grant_q & {NUM_REQ{out_ready}};
        end
        if (gnt_valid && out_ready) begin
          len_cnt_d = len_cnt_q - 1'b1;
          if (len_cnt_q == LEN_W'(1)) begin
            state_d     = ST_GUARD;
            grant_d     = '0;
            guard_cnt_d = '0;
          end
        end
`ifdef LINK_ARB_TIMEOUT_EN
        // Stall counter: consecutive cycles with the source idle; a transfer
        // clears it, a ready-only stall leaves it unchanged.
        if (gnt_valid && out_ready) begin
          stall_cnt_d = '0;
        end else if (!gnt_valid) begin
          if (stall_cnt_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
            stall_cnt_d = '0;
            abort_d     = 1'b1;
            state_d     = ST_GUARD;
            grant_d     = '0;
            guard_cnt_d = '0;
          end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end
`endif
      end
      ST_GUARD: begin
        guard_cnt_d = guard_cnt_q + 1'b1;
        if (guard_cnt_q == GRD_W'(GUARD_CYCLES - 1)) begin
          state_d     = ST_ARB;
          guard_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_ARB;
        grant_d = '0;
      end
    endcase
  end

  // State and counter registers; reset returns to an idle ARB immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ARB;
      grant_q     <= '0;
      gidx_q      <= '0;
      pre_cnt_q   <= '0;
      len_cnt_q   <= '0;
      guard_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      pre_cnt_q   <= pre_cnt_d;
      len_cnt_q   <= len_cnt_d;
      guard_cnt_q <= guard_cnt_d;
    end
  end

`ifdef LINK_ARB_TIMEOUT_EN
  // Timeout registers; abort is a registered one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      abort_q     <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      abort_q     <= abort_d;
    end
  end

  assign abort = abort_q;
`else
  // Timeout not built: PAYLOAD waits for the source indefinitely.
  assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_link_tx_arbiter.sv
// tb_link_tx_arbiter: directed + randomized checks of link_tx_arbiter against
// a frame-level model (round-robin winner, expected word list, guard gap).
// Timeout expectations follow LINK_ARB_TIMEOUT_EN when it is defined.
module tb_link_tx_arbiter;

  localparam int N  = 4;
  localparam int P  = 4;
  localparam int G  = 2;
  localparam int TO = 16;
  localparam logic [31:0] PW = 32'hA5A5_5A5A;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*8-1:0]  req_len;
  logic [N*32-1:0] req_data;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    grant;
  logic            busy;
  logic [31:0]     out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            scramble_en;
  logic            abort;

  int checks = 0;
  int errors = 0;
  int rr_ptr = N - 1;

  link_tx_arbiter #(
    .NUM_REQ        (N),
    .PREAMBLE_LEN   (P),
    .PREAMBLE_WORD  (PW),
    .GUARD_CYCLES   (G),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_len     (req_len),
    .req_data    (req_data),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .grant       (grant),
    .busy        (busy),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .scramble_en (scramble_en),
    .abort       (abort)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pack_obs(logic [N-1:0] g, logic b, logic v, logic [31:0] d,
                                           logic s, logic l, logic [N-1:0] r, logic a);
    return 64'({g, b, v, d, s, l, r, a});
  endfunction

  function automatic logic [63:0] dut_obs();
    return pack_obs(grant, busy, out_valid, out_data, scramble_en, out_last, req_ready, abort);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Round-robin rule: first requester found scanning from rr_ptr+1 with wrap.
  function automatic int model_winner(input logic [N-1:0] p);
    for (int k = 1; k <= N; k++) begin
      if (p[(rr_ptr + k) % N]) return (rr_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic drive_rand();
    req       = N'($urandom);
    req_len   = 32'($urandom);
    req_data  = {$urandom, $urandom, $urandom, $urandom};
    req_valid = N'($urandom);
    out_ready = 1'($urandom);
  endtask

  // One frame from the ARB cycle through the guard gap. vmode: 0 valid high,
  // 1 random, 2 one word then stall_len idle cycles. rmode: 0 ready high,
  // 1 random, 2 repeating 1,0,0,1.
  task automatic run_frame(input logic [N-1:0] pat, input int len, input int vmode,
                           input int rmode, input int stall_len, output int cycles);
    int w, total, sent, low_run, stalled, cyc;
    bit aborted, pre, ev;
    logic [31:0] pay [256];
    logic [31:0] ed;
    logic [N-1:0] eg, er;
    w = model_winner(pat);
    for (int i = 0; i < len; i++) pay[i] = $urandom;
    drive_rand();
    req = pat;
    req_len[w*8 +: 8] = 8'(len);
    if (rmode != 1) out_ready = 1'b1;
    @(negedge clk);
    chk("arb_cycle", dut_obs(), 64'd0);
    rr_ptr = w;
    @(posedge clk); #1;
    total = P + len; sent = 0; low_run = 0; stalled = 0; aborted = 0; cyc = 1;
    eg = N'(1) << w;
    while (sent < total && !aborted) begin
      drive_rand();
      if (rmode == 0) out_ready = 1'b1;
      if (rmode == 2) out_ready = ((cyc % 4) == 1) || ((cyc % 4) == 0);
      pre = (sent < P);
      if (!pre) req_data[w*32 +: 32] = pay[sent-P];
      if (vmode == 0) req_valid[w] = 1'b1;
      if (vmode == 2) begin
        if ((sent - P) == 1 && stalled < stall_len) begin
          req_valid[w] = 1'b0;
          stalled++;
        end else begin
          req_valid[w] = 1'b1;
        end
      end
      ev = pre ? 1'b1 : req_valid[w];
      ed = !ev ? 32'd0 : (pre ? PW : pay[sent-P]);
      er = (!pre && ev && out_ready) ? eg : '0;
      @(negedge clk);
      chk(pre ? "preamble" : "payload", dut_obs(),
          pack_obs(eg, 1'b1, ev, ed, ev && !pre, ev && (sent == total - 1), er, 1'b0));
      if (ev && out_ready) begin
        sent++;
        low_run = 0;
      end else if (!pre && !ev) begin
        low_run++;
`ifdef LINK_ARB_TIMEOUT_EN
        if (low_run == TO) aborted = 1;
`endif
      end
      @(posedge clk); #1;
      cyc++;
    end
    for (int gi = 0; gi < G; gi++) begin
      drive_rand();
      @(negedge clk);
      chk("guard", dut_obs(), pack_obs('0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, '0, aborted && gi == 0));
      @(posedge clk); #1;
      cyc++;
    end
    cycles = cyc;
    $display("frame pat=%b winner=%0d len=%0d vmode=%0d rmode=%0d cycles=%0d aborted=%0d",
             pat, w, len, vmode, rmode, cyc, aborted);
  endtask

  initial begin
    int cyc, w, exp_cyc;
    logic [N-1:0] pat;

    // Reset state.
    rst = 1'b1;
    drive_rand();
    @(negedge clk);
    chk("reset_state", dut_obs(), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request, length 3, everything ready.
    run_frame(4'b0001, 3, 0, 0, 0, cyc);
    chk("single_cycles", 64'(cyc), 64'(1 + P + 3 + G));

    // No requests: remains idle.
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      req = '0;
      @(negedge clk);
      chk("idle", dut_obs(), 64'd0);
      @(posedge clk); #1;
    end

    // Round robin with all requesting.
    for (int i = 0; i < 5; i++) begin
      run_frame(4'b1111, 1, 0, 0, 0, cyc);
      chk("rr_cycles", 64'(cyc), 64'(1 + P + 1 + G));
    end

    // Backpressure: fixed 1,0,0,1 pattern then random.
    run_frame(4'b0100, 2, 0, 2, 0, cyc);
    run_frame(4'b0110, 5, 1, 1, 0, cyc);

    // Zero length and maximum length.
    run_frame(4'b1000, 0, 0, 0, 0, cyc);
    chk("zero_len_cycles", 64'(cyc), 64'(1 + P + G));
    run_frame(4'b0010, 255, 0, 0, 0, cyc);
    chk("max_len_cycles", 64'(cyc), 64'(1 + P + 255 + G));

    // Long source stall after one payload word, then next requester's turn.
    run_frame(4'b1111, 5, 2, 0, 20, cyc);
`ifdef LINK_ARB_TIMEOUT_EN
    exp_cyc = 1 + P + 1 + TO + G;
`else
    exp_cyc = 1 + P + 5 + 20 + G;
`endif
    chk("stall_cycles", 64'(cyc), 64'(exp_cyc));
    run_frame(4'b1111, 1, 0, 0, 0, cyc);

    // Randomized frames.
    for (int i = 0; i < 40; i++) begin
      pat = N'($urandom);
      if (pat == '0) begin
        drive_rand();
        req = '0;
        @(negedge clk);
        chk("rand_idle", dut_obs(), 64'd0);
        @(posedge clk); #1;
      end else begin
        run_frame(pat, $urandom_range(0, 6), 1, 1, 0, cyc);
      end
    end

    // Asynchronous reset during the second payload word.
    drive_rand();
    req = 4'b0110;
    req_valid = '1;
    out_ready = 1'b1;
    w = model_winner(req);
    req_len[w*8 +: 8] = 8'd5;
    @(negedge clk);
    chk("rst_test_arb", dut_obs(), 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < P + 1; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rst_test_mid", 64'({grant, busy, out_valid, scramble_en}),
        64'({N'(1) << w, 1'b1, 1'b1, 1'b1}));
    #1 rst = 1'b1;
    #1;
    chk("rst_async_clear", dut_obs(), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rr_ptr = N - 1;
    run_frame(4'b1111, 2, 0, 0, 0, cyc);
    chk("post_rst_cycles", 64'(cyc), 64'(1 + P + 2 + G));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
